// File: rtl/avalon_wait_pkg.sv
// Shared types and constants for the Avalon wait-state generator.
// LFSR_TAPS marks taps 16,14,13,11 of a left-shifting Fibonacci LFSR.
package avalon_wait_pkg;

   typedef enum logic {
      IDLE,
      WAIT
   } state_e;

   localparam int          WAIT_W    = 16;
   localparam logic [15:0] LFSR_TAPS = 16'hB400;

   function automatic logic [15:0] lfsr_step(input logic [15:0] s);
      return {s[14:0], ^(s & LFSR_TAPS)};
   endfunction

endpackage

// File: rtl/avalon_wait_gen_lfsr16.sv
// 16-bit Fibonacci LFSR for wait-state jitter; built only when the
// RANDOM_WAIT_EN macro is defined.
`ifdef RANDOM_WAIT_EN
module lfsr16
   import avalon_wait_pkg::*;
#(
   parameter logic [15:0] SEED = 16'hACE1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        adv,
   output logic [15:0] q
);

   logic [15:0] lfsr_q;
   logic [15:0] lfsr_d;

   always_comb begin
      lfsr_d = lfsr_q;
      if (adv) begin
         lfsr_d = lfsr_step(lfsr_q);
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         lfsr_q <= SEED;
      end else begin
         lfsr_q <= lfsr_d;
      end
   end

   assign q = lfsr_q;

endmodule
`endif

// File: rtl/avalon_wait_gen.sv
// Avalon-MM wait-state generator: stalls each master access N cycles.
// Define RANDOM_WAIT_EN to add LFSR jitter to N.
module avalon_wait_gen
   import avalon_wait_pkg::*;
#(
   parameter int          READ_WAIT   = 2,
   parameter int          WRITE_WAIT  = 3,
   parameter int          DATA_WIDTH  = 32,
   parameter logic [15:0] LFSR_SEED   = 16'hACE1,
   parameter logic [15:0] JITTER_MASK = 16'h0003
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    m_read,
   input  logic                    m_write,
   input  logic [31:0]             m_address,
   input  logic [DATA_WIDTH-1:0]   m_writedata,
   input  logic [DATA_WIDTH/8-1:0] m_byteenable,
   output logic                    m_waitrequest,
   output logic [DATA_WIDTH-1:0]   m_readdata,
   output logic                    s_read,
   output logic                    s_write,
   output logic [31:0]             s_address,
   output logic [DATA_WIDTH-1:0]   s_writedata,
   output logic [DATA_WIDTH/8-1:0] s_byteenable,
   input  logic [DATA_WIDTH-1:0]   s_readdata,
   output logic                    proto_err,
   output logic [31:0]             stall_count
);

   localparam int BE_W = DATA_WIDTH / 8;
   localparam logic [WAIT_W-1:0] RD_N = WAIT_W'(READ_WAIT);
   localparam logic [WAIT_W-1:0] WR_N = WAIT_W'(WRITE_WAIT);

   if (READ_WAIT > 65535 - int'(JITTER_MASK) ||
       WRITE_WAIT > 65535 - int'(JITTER_MASK)) begin : g_bad_wait
      $error("wait parameter exceeds 16-bit counter range");
   end
   if (LFSR_SEED == 16'h0) begin : g_bad_seed
      $error("LFSR seed must be nonzero");
   end

   state_e              state_q, state_d;
   logic [WAIT_W-1:0]   cnt_q, cnt_d;
   logic                wr_q, wr_d;
   logic [31:0]         addr_q, addr_d;
   logic [DATA_WIDTH-1:0] data_q, data_d;
   logic [BE_W-1:0]     be_q, be_d;
   logic                err_q, err_d;
   logic [31:0]         stall_q, stall_d;

   logic                accept;
   logic [WAIT_W-1:0]   n_wait;
   logic                wait_o;
   logic                s_rd;
   logic                s_wr;
   logic [DATA_WIDTH-1:0] rdata;

`ifdef RANDOM_WAIT_EN
   logic [15:0] lfsr;

   lfsr16 #(
      .SEED (LFSR_SEED)
   ) u_lfsr (
      .clk   (clk),
      .reset (reset),
      .adv   (accept),
      .q     (lfsr)
   );

   assign n_wait = (m_write ? WR_N : RD_N) + (lfsr & JITTER_MASK);
`else
   assign n_wait = m_write ? WR_N : RD_N;
`endif

   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      wr_d         = wr_q;
      addr_d       = addr_q;
      data_d       = data_q;
      be_d         = be_q;
      err_d        = err_q;
      accept       = 1'b0;
      wait_o       = 1'b0;
      s_rd         = 1'b0;
      s_wr         = 1'b0;
      s_address    = addr_q;
      s_writedata  = data_q;
      s_byteenable = be_q;
      rdata        = '0;
      unique case (state_q)
         IDLE: begin
            if (m_read || m_write) begin
               accept = 1'b1;
               if (m_read && m_write) begin
                  err_d = 1'b1;
               end
               if (n_wait == '0) begin
                  s_rd         = ~m_write;
                  s_wr         = m_write;
                  s_address    = m_address;
                  s_writedata  = m_writedata;
                  s_byteenable = m_byteenable;
                  if (!m_write) begin
                     rdata = s_readdata;
                  end
               end else begin
                  wait_o  = 1'b1;
                  state_d = WAIT;
                  cnt_d   = n_wait - 16'd1;
                  wr_d    = m_write;
                  addr_d  = m_address;
                  data_d  = m_writedata;
                  be_d    = m_byteenable;
               end
            end
         end
         WAIT: begin
            // master withdrew mid-transfer: drop it without a strobe
            if (wr_q ? !m_write : !m_read) begin
               state_d = IDLE;
               cnt_d   = '0;
               err_d   = 1'b1;
            end else if (cnt_q == '0) begin
               s_rd    = ~wr_q;
               s_wr    = wr_q;
               state_d = IDLE;
               if (!wr_q) begin
                  rdata = s_readdata;
               end
            end else begin
               wait_o = 1'b1;
               cnt_d  = cnt_q - 16'd1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign m_waitrequest = wait_o & ~reset;
   assign s_read        = s_rd & ~reset;
   assign s_write       = s_wr & ~reset;
   assign m_readdata    = reset ? '0 : rdata;
   assign proto_err     = err_q;
   assign stall_count   = stall_q;

   always_comb begin
      stall_d = stall_q;
      if (m_waitrequest && (stall_q != 32'hFFFF_FFFF)) begin
         stall_d = stall_q + 32'd1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         wr_q    <= 1'b0;
         addr_q  <= '0;
         data_q  <= '0;
         be_q    <= '0;
         err_q   <= 1'b0;
         stall_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         wr_q    <= wr_d;
         addr_q  <= addr_d;
         data_q  <= data_d;
         be_q    <= be_d;
         err_q   <= err_d;
         stall_q <= stall_d;
      end
   end

endmodule

// File: tb/tb_avalon_wait_gen.sv
// Scoreboard bench for avalon_wait_gen: random and directed transfers
// against a transaction-level model of stall length and slave strobes.
module tb_avalon_wait_gen;

   localparam int RW = 2;
   localparam int WW = 3;
   localparam logic [15:0] SEED = 16'hACE1;

   logic        clk = 1'b0;
   logic        reset;
   logic        m_read, m_write;
   logic [31:0] m_address, m_writedata;
   logic [3:0]  m_byteenable;
   logic        m_waitrequest;
   logic [31:0] m_readdata;
   logic        s_read, s_write;
   logic [31:0] s_address, s_writedata;
   logic [3:0]  s_byteenable;
   logic [31:0] slv_data;
   logic        proto_err;
   logic [31:0] stall_count;

   logic        z_read, z_write;
   logic [31:0] z_address, z_writedata;
   logic [3:0]  z_byteenable;
   logic        z_wr;
   logic [31:0] z_m_readdata;
   logic        z_s_read, z_s_write;
   logic [31:0] z_s_address, z_s_writedata;
   logic [3:0]  z_s_byteenable;
   logic [31:0] z_sdata;
   logic        z_err;
   logic [31:0] z_stall;

   always #5 clk = ~clk;

   avalon_wait_gen #(
      .READ_WAIT  (RW),
      .WRITE_WAIT (WW)
   ) u_dut (
      .clk           (clk),
      .reset         (reset),
      .m_read        (m_read),
      .m_write       (m_write),
      .m_address     (m_address),
      .m_writedata   (m_writedata),
      .m_byteenable  (m_byteenable),
      .m_waitrequest (m_waitrequest),
      .m_readdata    (m_readdata),
      .s_read        (s_read),
      .s_write       (s_write),
      .s_address     (s_address),
      .s_writedata   (s_writedata),
      .s_byteenable  (s_byteenable),
      .s_readdata    (slv_data),
      .proto_err     (proto_err),
      .stall_count   (stall_count)
   );

   avalon_wait_gen #(
      .READ_WAIT  (0),
      .WRITE_WAIT (1)
   ) u_zero (
      .clk           (clk),
      .reset         (reset),
      .m_read        (z_read),
      .m_write       (z_write),
      .m_address     (z_address),
      .m_writedata   (z_writedata),
      .m_byteenable  (z_byteenable),
      .m_waitrequest (z_wr),
      .m_readdata    (z_m_readdata),
      .s_read        (z_s_read),
      .s_write       (z_s_write),
      .s_address     (z_s_address),
      .s_writedata   (z_s_writedata),
      .s_byteenable  (z_s_byteenable),
      .s_readdata    (z_sdata),
      .proto_err     (z_err),
      .stall_count   (z_stall)
   );

   typedef struct {
      bit          wr;
      logic [31:0] addr;
      logic [31:0] data;
      logic [3:0]  be;
      int          stall;
   } exp_t;

   exp_t        sbq[$];
   int          checks = 0;
   int          failures = 0;
   int          exp_total;
   int          stall_run;
   logic [15:0] ref_lfsr;

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // stall length of the next accepted request, from the parameters
   // plus (in the jitter build) a shift-register model of the LFSR
   function automatic int model_wait(input bit wr);
      int n;
      int x;
      int fb;
      n = wr ? WW : RW;
`ifdef RANDOM_WAIT_EN
      x  = int'(ref_lfsr);
      n  = n + (x % 4);
      fb = ((x >> 15) ^ (x >> 13) ^ (x >> 12) ^ (x >> 10)) % 2;
      ref_lfsr = 16'((x * 2 + fb) % 65536);
`endif
      return n;
   endfunction

   task automatic idle(input int k);
      repeat (k) begin
         @(posedge clk);
         #1;
         m_read  = 1'b0;
         m_write = 1'b0;
      end
   endtask

   task automatic do_txn(input bit wr, input bit both, input logic [31:0] a,
                         input logic [31:0] d, input logic [3:0] be,
                         input logic [31:0] rd, input bit chg);
      exp_t e;
      int   guard;
      @(posedge clk);
      #1;
      e.wr    = wr | both;
      e.addr  = a;
      e.data  = e.wr ? d : rd;
      e.be    = be;
      e.stall = model_wait(e.wr);
      exp_total += e.stall;
      sbq.push_back(e);
      slv_data     = rd;
      m_read       = ~wr | both;
      m_write      = wr | both;
      m_address    = a;
      m_writedata  = d;
      m_byteenable = be;
      guard = 0;
      while (1) begin
         @(negedge clk);
         if (!m_waitrequest) break;
         guard++;
         if (guard > 200) begin
            checks++;
            failures++;
            $display("FAIL txn_timeout: waitrequest stuck after %0d cycles", guard);
            break;
         end
         @(posedge clk);
         #1;
         if (chg) begin
            m_address    = $urandom;
            m_writedata  = $urandom;
            m_byteenable = 4'($urandom);
         end
      end
   endtask

   always @(negedge clk) begin
      exp_t e;
      if (reset) begin
         stall_run = 0;
      end else begin
         if (m_waitrequest) stall_run++;
         if (s_read || s_write) begin
            if (sbq.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL unexpected_strobe: rd=%b wr=%b addr=%h", s_read,
                        s_write, s_address);
            end else begin
               e = sbq.pop_front();
               chk("strobe_write", 32'(s_write), 32'(e.wr));
               chk("strobe_read", 32'(s_read), 32'(!e.wr));
               chk("slave_addr", s_address, e.addr);
               chk("slave_be", 32'(s_byteenable), 32'(e.be));
               if (e.wr) chk("slave_wdata", s_writedata, e.data);
               else chk("master_rdata", m_readdata, e.data);
               chk("stall_cycles", 32'(stall_run), 32'(e.stall));
            end
            stall_run = 0;
         end else begin
            chk("rdata_zero", m_readdata, 32'h0);
            if (!m_read && !m_write) stall_run = 0;
         end
      end
   end

   initial begin
      #5_000_000;
      $display("FAIL global_timeout: bench did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      int gap;
      int n;
      logic [31:0] zd;
      reset = 1'b1;
      m_read = 1'b1;
      m_write = 1'b0;
      m_address = 32'h40;
      m_writedata = '0;
      m_byteenable = 4'hF;
      slv_data = 32'h5555_AAAA;
      z_read = 1'b0;
      z_write = 1'b0;
      z_address = '0;
      z_writedata = '0;
      z_byteenable = '0;
      z_sdata = '0;
      ref_lfsr = SEED;
      exp_total = 0;
      stall_run = 0;

      repeat (2) @(negedge clk);
      chk("rst_waitrequest", 32'(m_waitrequest), 0);
      chk("rst_s_read", 32'(s_read), 0);
      chk("rst_s_write", 32'(s_write), 0);
      chk("rst_proto_err", 32'(proto_err), 0);
      chk("rst_stall_count", stall_count, 0);
      chk("rst_readdata", m_readdata, 0);
      @(posedge clk);
      #1;
      m_read = 1'b0;
      reset  = 1'b0;

      do_txn(0, 0, 32'h10, 32'h0, 4'hF, 32'hDEAD_BEEF, 0);
      idle(1);
      chk("stall_count_read", stall_count, 32'(exp_total));

      do_txn(1, 0, 32'h20, 32'h1234_5678, 4'b0011, 32'h0, 1);
      idle(1);
      chk("stall_count_write", stall_count, 32'(exp_total));

      for (int i = 0; i < 40; i++) begin
         do_txn(1'($urandom), 0, $urandom, $urandom, 4'($urandom),
                $urandom, 1'($urandom));
         gap = int'($urandom_range(0, 2));
         idle(gap);
      end
      idle(1);
      chk("proto_err_clean", 32'(proto_err), 0);
      chk("stall_count_random", stall_count, 32'(exp_total));

      // read withdrawn after its first stall cycle
      @(posedge clk);
      #1;
      n = model_wait(0);
      exp_total += 1;
      m_read = 1'b1;
      m_address = 32'h80;
      @(negedge clk);
      chk("abort_stall", 32'(m_waitrequest), 1);
      @(posedge clk);
      #1;
      m_read = 1'b0;
      @(negedge clk);
      chk("abort_no_stall", 32'(m_waitrequest), 0);
      @(posedge clk);
      #1;
      chk("abort_proto_err", 32'(proto_err), 1);
      chk("abort_stall_count", stall_count, 32'(exp_total));
      do_txn(0, 0, 32'h84, 32'h0, 4'hF, 32'hCAFE_F00D, 0);
      idle(1);

      // reset during the second wait cycle of a write
      @(posedge clk);
      #1;
      n = model_wait(1);
      m_write = 1'b1;
      m_address = 32'h90;
      m_writedata = 32'h0BAD_0BAD;
      @(negedge clk);
      chk("prereset_stall", 32'(m_waitrequest), 1);
      @(posedge clk);
      #1;
      reset = 1'b1;
      ref_lfsr = SEED;
      exp_total = 0;
      @(negedge clk);
      chk("midrst_waitrequest", 32'(m_waitrequest), 0);
      chk("midrst_s_write", 32'(s_write), 0);
      chk("midrst_proto_err", 32'(proto_err), 0);
      chk("midrst_stall_count", stall_count, 0);
      chk("midrst_readdata", m_readdata, 0);
      @(posedge clk);
      #1;
      m_write = 1'b0;
      reset = 1'b0;
      idle(1);
      do_txn(1, 0, 32'hA0, 32'h600D_600D, 4'b1100, 32'h0, 0);
      idle(1);
      chk("postrst_stall_count", stall_count, 32'(exp_total));

      do_txn(0, 1, 32'hB0, 32'h7777_1111, 4'hF, 32'h0, 0);
      idle(2);
      chk("both_proto_err", 32'(proto_err), 1);
      chk("final_stall_count", stall_count, 32'(exp_total));
      chk("scoreboard_empty", 32'(sbq.size()), 0);

`ifndef RANDOM_WAIT_EN
      for (int i = 0; i < 4; i++) begin
         @(posedge clk);
         #1;
         z_read = 1'b1;
         z_address = 32'(i * 4 + 32'h100);
         z_sdata = $urandom;
         @(negedge clk);
         chk("zero_wr", 32'(z_wr), 0);
         chk("zero_s_read", 32'(z_s_read), 1);
         chk("zero_addr", z_s_address, 32'(i * 4 + 32'h100));
         chk("zero_rdata", z_m_readdata, z_sdata);
      end
      @(posedge clk);
      #1;
      z_read = 1'b0;
      @(negedge clk);
      chk("zero_idle_s_read", 32'(z_s_read), 0);
      chk("zero_stall_count", z_stall, 0);

      zd = 32'hFACE_0001;
      @(posedge clk);
      #1;
      z_write = 1'b1;
      z_address = 32'h200;
      z_writedata = zd;
      z_byteenable = 4'b0101;
      @(negedge clk);
      chk("one_wr_stall", 32'(z_wr), 1);
      chk("one_no_strobe", 32'(z_s_write), 0);
      @(posedge clk);
      #1;
      z_writedata = 32'hFFFF_FFFF;
      z_address = 32'h0;
      @(negedge clk);
      chk("one_wr_done", 32'(z_wr), 0);
      chk("one_s_write", 32'(z_s_write), 1);
      chk("one_wdata", z_s_writedata, zd);
      chk("one_addr", z_s_address, 32'h200);
      chk("one_be", 32'(z_s_byteenable), 32'h5);
      @(posedge clk);
      #1;
      z_write = 1'b0;
      @(negedge clk);
      chk("one_stall_count", z_stall, 1);
      chk("one_proto_err", 32'(z_err), 0);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/avalon_wait_gen.md
AVALON_WAIT_GEN -- requirements
Module: avalon_wait_gen

Interface
REQ-001 The block SHALL have parameter READ_WAIT, default 2, giving the number of stall cycles applied to each read.
REQ-002 The block SHALL have parameter WRITE_WAIT, default 3, giving the number of stall cycles applied to each write.
REQ-003 The block SHALL have parameter DATA_WIDTH, default 32, giving the data bus width; the byteenable width is DATA_WIDTH/8.
REQ-004 The block SHALL have parameter LFSR_SEED, default 16'hACE1, giving the LFSR reset value; it is used only with RANDOM_WAIT_EN.
REQ-005 The block SHALL have parameter JITTER_MASK, default 16'h0003, giving the mask on LFSR bits added to the wait count; it is used only with RANDOM_WAIT_EN.
REQ-006 Ports SHALL be:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- m_read  in  1  master read request
- m_write  in  1  master write request
- m_address  in  32  master address
- m_writedata  in  DATA_WIDTH  master write data
- m_byteenable  in  DATA_WIDTH/8  master byte enables
- m_waitrequest  out  1  stall to master
- m_readdata  out  DATA_WIDTH  read data to master
- s_read  out  1  slave read strobe
- s_write  out  1  slave write strobe
- s_address  out  32  slave address
- s_writedata  out  DATA_WIDTH  slave write data
- s_byteenable  out  DATA_WIDTH/8  slave byte enables
- s_readdata  in  DATA_WIDTH  slave read data, combinational, valid in the strobe cycle
- proto_err  out  1  sticky protocol-error flag
- stall_count  out  32  saturating count of cycles with m_waitrequest=1

Function
REQ-007 The FSM SHALL have two states, IDLE and WAIT.
REQ-008 In IDLE, when a request arrives with a wait count N>0, m_waitrequest SHALL be 1 combinationally in that same cycle.
REQ-009 On the IDLE-to-WAIT transition, the block SHALL latch the operation, address, writedata and byteenable, and load the counter with N-1.
REQ-010 In WAIT, m_waitrequest SHALL be 1 and the counter SHALL decrement while it is nonzero.
REQ-011 In the WAIT cycle with counter==0 (the completion cycle), the block SHALL:
- set m_waitrequest=0;
- assert s_read or s_write for that single cycle, using the latched address, data and byteenable;
- on a read, drive m_readdata=s_readdata;
- move to IDLE on the next edge.
REQ-012 The stall per transfer SHALL be exactly N cycles, and the slave SHALL see exactly one strobe per completed transfer.
REQ-013 When N=0, the request SHALL pass through from IDLE in the same cycle: no stall, strobe issued, the FSM stays in IDLE.
REQ-014 m_readdata SHALL be 0 in every cycle other than a read completion or a read passthrough.
REQ-015 When m_read and m_write are both 1, the write SHALL be performed and proto_err SHALL be set.
REQ-016 When the master deasserts its request while in WAIT, the block SHALL abort to IDLE, issue no slave strobe, and set proto_err.
REQ-017 Changes to m_address or m_writedata during WAIT SHALL be ignored; the latched values SHALL be used.
REQ-018 The block SHALL accept back-to-back requests: a request present in the cycle after a completion SHALL start a new transfer.
REQ-019 stall_count SHALL increment on every cycle with m_waitrequest=1 and SHALL saturate at 32'hFFFFFFFF.
REQ-020 Wait counters SHALL be 16 bits wide; READ_WAIT and WRITE_WAIT SHALL each be less than or equal to 65535-JITTER_MASK.

Reset
REQ-021 While reset=1, the block SHALL hold: state=IDLE, counter=0, proto_err=0, stall_count=0, LFSR=LFSR_SEED, and s_read=s_write=0.
REQ-022 Reset asserted mid-transfer SHALL abort the transfer with no slave strobe.
REQ-023 While reset=1, m_waitrequest SHALL be 0.

Configuration
REQ-024 With macro RANDOM_WAIT_EN defined, N SHALL be the base wait plus (LFSR & JITTER_MASK).
REQ-025 With RANDOM_WAIT_EN defined, the 16-bit Fibonacci LFSR (taps 16,14,13,11) SHALL advance once per accepted request.
REQ-026 Without RANDOM_WAIT_EN, N SHALL be fixed at READ_WAIT or WRITE_WAIT, and no LFSR logic SHALL be synthesised.

Structure
REQ-027 Package avalon_wait_pkg SHALL hold the state enum {IDLE, WAIT}, the constant WAIT_W=16, and the constant LFSR_TAPS.
REQ-028 The LFSR SHALL be implemented as sub-module lfsr16, instantiated only under RANDOM_WAIT_EN.

Verification
REQ-029 Read with READ_WAIT=2 at address 0x10, slave data 0xDEADBEEF -> m_waitrequest high for 2 cycles, one s_read pulse, m_readdata=0xDEADBEEF in the completion cycle, stall_count=2.
REQ-030 Write with WRITE_WAIT=3, data 0x12345678, byteenable 4'b0011 -> 3 stall cycles, one s_write pulse carrying the latched data and byteenable, even when m_writedata changes during WAIT.
REQ-031 READ_WAIT=0, four consecutive reads -> no waitrequest, four s_read pulses in four cycles, stall_count=0.
REQ-032 m_read dropped after 1 stall cycle of a READ_WAIT=2 read -> no s_read pulse, proto_err=1, FSM back in IDLE.
REQ-033 reset pulsed during the second wait cycle of a write -> no s_write pulse, all outputs at reset values; a subsequent write completes normally.
REQ-034 With RANDOM_WAIT_EN, 100 reads with READ_WAIT=1 -> every stall is in 1..4 cycles, and the sequence matches a reference LFSR model from 0xACE1.
